// File: rtl/instr_encoder_if.sv
// instr_encoder_if: request/response bus between a producer and the instruction encoder
interface instr_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] ctrl;
    logic [12:0] operand;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_word;
    logic        err;
    logic [7:0]  err_count;
    logic [3:0]  level;

    modport master (
        output in_valid, ctrl, operand, out_ready,
        input  in_ready, out_valid, out_word, err, err_count, level
    );

    modport slave (
        input  in_valid, ctrl, operand, out_ready,
        output in_ready, out_valid, out_word, err, err_count, level
    );
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder: one-hot control vector to 16-bit instruction word, buffered in a small output FIFO
module instr_encoder #(
    parameter int DEPTH = 4
) (
    input logic           clk,
    input logic           rst_n,
    instr_encoder_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [3:0] DEPTH_L = 4'(DEPTH);

    // element 31 (first listed) is ADD, element 0 is GEQ, matching ctrl bit order
    localparam logic [31:0][15:0] BASE = {
        16'h0000, 16'h0200, 16'h0400, 16'h0600, 16'h0800, 16'h0A00, 16'h0C00, 16'h0E00,
        16'h1000, 16'h1800, 16'h2000, 16'h3000, 16'h3800, 16'h3C00, 16'h4000, 16'h5000,
        16'h7080, 16'h70C0, 16'h7100, 16'h7108, 16'h7400, 16'h7500, 16'h7508, 16'h7600,
        16'h7700, 16'h7708, 16'h7800, 16'h7C00, 16'h8000, 16'hA000, 16'hC000, 16'hE000
    };
    localparam logic [31:0][15:0] MASK = {
        16'h01FF, 16'h01FF, 16'h01FF, 16'h01FF, 16'h01FF, 16'h01FF, 16'h01FF, 16'h01FF,
        16'h07FF, 16'h07FF, 16'h0FFF, 16'h07FF, 16'h03FF, 16'h03FF, 16'h0FFF, 16'h0FFF,
        16'h003F, 16'h003F, 16'h0007, 16'h0007, 16'h0007, 16'h0007, 16'h0007, 16'h0007,
        16'h0007, 16'h0007, 16'h03FF, 16'h03FF, 16'h1FFF, 16'h1FFF, 16'h1FFF, 16'h1FFF
    };

    logic [15:0]   mem_q [DEPTH];
    logic [15:0]   mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [3:0]    level_q, level_d;
    logic          err_q, err_d;
    logic [7:0]    err_count_q, err_count_d;
    logic          legal, accept, push, pop;
    logic [15:0]   base, mask, enc;

    assign bus.in_ready  = level_q < DEPTH_L;
    assign bus.out_valid = level_q != 4'd0;
    assign bus.out_word  = mem_q[rd_ptr_q];
    assign bus.err       = err_q;
    assign bus.err_count = err_count_q;
    assign bus.level     = level_q;

    // one-hot legality check and table-driven encoding (OR-reduce is exact for one-hot ctrl)
    always_comb begin
        base = '0;
        mask = '0;
        for (int i = 0; i < 32; i++) begin
            base = base | (bus.ctrl[i] ? BASE[i] : 16'h0000);
            mask = mask | (bus.ctrl[i] ? MASK[i] : 16'h0000);
        end
        legal = (bus.ctrl != 32'd0) && ((bus.ctrl & (bus.ctrl - 32'd1)) == 32'd0);
        enc   = base | ({3'b000, bus.operand} & mask);
    end

    // handshake, FIFO pointers/occupancy and error counter next state
    always_comb begin
        accept   = bus.in_valid && bus.in_ready;
        push     = accept && legal;
        pop      = (level_q != 4'd0) && bus.out_ready;
        mem_d    = mem_q;
        if (push) mem_d[wr_ptr_q] = enc;
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        level_d  = level_q + {3'b000, push} - {3'b000, pop};
        err_d    = accept && !legal;
        err_count_d = (err_d && err_count_q != 8'hFF) ? err_count_q + 8'd1 : err_count_q;
    end

    // state registers, reset discards FIFO contents immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            err_q       <= 1'b0;
            err_count_q <= '0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            err_q       <= err_d;
            err_count_q <= err_count_d;
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed self-checking bench for instr_encoder (DEPTH=4)
module tb_instr_encoder;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   total = 0;
    int   passed = 0;

    instr_encoder_if bus();

    instr_encoder #(.DEPTH(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0;
        bus.ctrl = 32'd0;
        bus.operand = 13'd0;
        bus.out_ready = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        total++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", bus.in_ready); else passed++;
        total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", bus.out_valid); else passed++;
        total++; if (bus.level !== 4'd0) $display("FAIL reset_level got %0d want 0", bus.level); else passed++;
        total++; if (bus.err !== 1'b0) $display("FAIL reset_err got %b want 0", bus.err); else passed++;
        total++; if (bus.err_count !== 8'd0) $display("FAIL reset_err_count got %0d want 0", bus.err_count); else passed++;
        total++; if (bus.out_word !== 16'h0000) $display("FAIL reset_out_word got %h want 0000", bus.out_word); else passed++;
        step();
        #2 rst_n = 1'b1;
    endtask

    task automatic test_basic();
        bus.in_valid = 1'b1;
        bus.ctrl = 32'h8000_0000;
        bus.operand = 13'h01FF;
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        total++; if (bus.out_valid !== 1'b1) $display("FAIL basic_valid got %b want 1", bus.out_valid); else passed++;
        total++; if (bus.out_word !== 16'h01FF) $display("FAIL basic_word got %h want 01ff", bus.out_word); else passed++;
        total++; if (bus.level !== 4'd1) $display("FAIL basic_level got %0d want 1", bus.level); else passed++;
        step();
        total++; if (bus.out_valid !== 1'b0) $display("FAIL basic_drain got %b want 0", bus.out_valid); else passed++;
    endtask

    task automatic test_encode();
        logic [31:0] c [10] = '{32'h0800_0000, 32'h0000_0040, 32'h0000_0001, 32'h0080_0000, 32'h0000_8000,
                                32'h0000_2000, 32'h0000_0010, 32'h0001_0000, 32'h0004_0000, 32'h0100_0000};
        logic [12:0] o [10] = '{13'h1FFF, 13'h0005, 13'h1234, 13'h1FFF, 13'h00FF,
                                13'h000F, 13'h1FFF, 13'h0ABC, 13'h0555, 13'h0003};
        logic [15:0] e [10] = '{16'h09FF, 16'h770D, 16'hF234, 16'h17FF, 16'h70BF,
                                16'h7107, 16'h7FFF, 16'h5ABC, 16'h3D55, 16'h0E03};
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            bus.ctrl = c[i];
            bus.operand = o[i];
            step();
            bus.in_valid = 1'b0;
            total++; if (bus.out_valid !== 1'b1 || bus.out_word !== e[i])
                $display("FAIL encode_%0d ctrl %h got valid %b word %h want valid 1 word %h", i, c[i], bus.out_valid, bus.out_word, e[i]);
            else passed++;
            step();
        end
    endtask

    task automatic test_illegal();
        bus.in_valid = 1'b1;
        bus.ctrl = 32'd0;
        bus.operand = 13'h0011;
        step();
        total++; if (bus.err !== 1'b1) $display("FAIL illegal_err_zero got %b want 1", bus.err); else passed++;
        total++; if (bus.level !== 4'd0 || bus.out_valid !== 1'b0) $display("FAIL illegal_zero_level got %0d/%b want 0/0", bus.level, bus.out_valid); else passed++;
        bus.ctrl = 32'h0000_0003;
        step();
        bus.in_valid = 1'b0;
        total++; if (bus.err !== 1'b1) $display("FAIL illegal_err_multi got %b want 1", bus.err); else passed++;
        total++; if (bus.err_count !== 8'd2) $display("FAIL illegal_count got %0d want 2", bus.err_count); else passed++;
        step();
        total++; if (bus.err !== 1'b0) $display("FAIL illegal_err_clear got %b want 0", bus.err); else passed++;
        total++; if (bus.out_valid !== 1'b0 || bus.level !== 4'd0) $display("FAIL illegal_empty got %b/%0d want 0/0", bus.out_valid, bus.level); else passed++;
    endtask

    task automatic test_full();
        bus.out_ready = 1'b0;
        bus.ctrl = 32'h0020_0000;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.operand = 13'(16 + i);
            step();
        end
        total++; if (bus.level !== 4'd4) $display("FAIL full_level got %0d want 4", bus.level); else passed++;
        total++; if (bus.in_ready !== 1'b0) $display("FAIL full_in_ready got %b want 0", bus.in_ready); else passed++;
        bus.operand = 13'h0014;
        step();
        total++; if (bus.level !== 4'd4) $display("FAIL full_fifth_level got %0d want 4", bus.level); else passed++;
        total++; if (bus.out_word !== 16'h2010) $display("FAIL full_stall_word got %h want 2010", bus.out_word); else passed++;
        step();
        bus.in_valid = 1'b0;
        total++; if (bus.out_word !== 16'h2010) $display("FAIL full_stall_hold got %h want 2010", bus.out_word); else passed++;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++; if (bus.out_valid !== 1'b1 || bus.out_word !== 16'(16'h2010 + i))
                $display("FAIL full_drain_%0d got %b/%h want 1/%h", i, bus.out_valid, bus.out_word, 16'(16'h2010 + i));
            else passed++;
            step();
        end
        total++; if (bus.out_valid !== 1'b0 || bus.level !== 4'd0) $display("FAIL full_empty got %b/%0d want 0/0", bus.out_valid, bus.level); else passed++;
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b0;
        bus.ctrl = 32'h0000_0008;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.operand = 13'(i);
            step();
        end
        bus.out_ready = 1'b1;
        total++; if (bus.in_ready !== 1'b0) $display("FAIL b2b_full_ready got %b want 0", bus.in_ready); else passed++;
        for (int c = 0; c < 10; c++) begin
            bus.operand = 13'(c == 0 ? 4 : 3 + c);
            total++; if (bus.out_valid !== 1'b1 || bus.out_word !== 16'(16'h8000 + c))
                $display("FAIL b2b_word_%0d got %b/%h want 1/%h", c, bus.out_valid, bus.out_word, 16'(16'h8000 + c));
            else passed++;
            if (c > 0) begin
                total++; if (bus.level !== 4'd3 || bus.in_ready !== 1'b1)
                    $display("FAIL b2b_level_%0d got %0d/%b want 3/1", c, bus.level, bus.in_ready);
                else passed++;
            end
            step();
        end
        #2 rst_n = 1'b0;
        #1;
        total++; if (bus.level !== 4'd0 || bus.out_valid !== 1'b0) $display("FAIL async_reset got %0d/%b want 0/0", bus.level, bus.out_valid); else passed++;
        total++; if (bus.err_count !== 8'd0 || bus.in_ready !== 1'b1) $display("FAIL async_reset_cnt got %0d/%b want 0/1", bus.err_count, bus.in_ready); else passed++;
        #2 rst_n = 1'b1;
        bus.out_ready = 1'b0;
        bus.ctrl = 32'h0000_0001;
        bus.operand = 13'h0001;
        step();
        total++; if (bus.out_valid !== 1'b1 || bus.out_word !== 16'hE001 || bus.level !== 4'd1)
            $display("FAIL post_reset_accept got %b/%h/%0d want 1/e001/1", bus.out_valid, bus.out_word, bus.level);
        else passed++;
        bus.ctrl = 32'd0;
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        total++; if (bus.level !== 4'd0 || bus.err !== 1'b1 || bus.err_count !== 8'd1)
            $display("FAIL illegal_with_pop got %0d/%b/%0d want 0/1/1", bus.level, bus.err, bus.err_count);
        else passed++;
    endtask

    task automatic test_saturate();
        bus.in_valid = 1'b1;
        bus.ctrl = 32'hFFFF_FFFF;
        repeat (253) step();
        total++; if (bus.err_count !== 8'd254) $display("FAIL sat_254 got %0d want 254", bus.err_count); else passed++;
        step();
        total++; if (bus.err_count !== 8'd255) $display("FAIL sat_255 got %0d want 255", bus.err_count); else passed++;
        repeat (6) step();
        bus.in_valid = 1'b0;
        total++; if (bus.err_count !== 8'd255 || bus.err !== 1'b1) $display("FAIL sat_hold got %0d/%b want 255/1", bus.err_count, bus.err); else passed++;
        step();
        total++; if (bus.err !== 1'b0 || bus.level !== 4'd0 || bus.err_count !== 8'd255)
            $display("FAIL sat_end got %b/%0d/%0d want 0/0/255", bus.err, bus.level, bus.err_count);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_encode();
        test_illegal();
        test_full();
        test_back_to_back();
        test_saturate();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
